clkdiv_prog: RTL

Multi-channel, runtime-programmable fabric clock divider for the SDRAM tester. It produces, per channel, a divided square-wave `clk_out` and a single-cycle clock-enable `ce` from one fabric clock. Divisor changes are glitch-free: every update is applied only at a period boundary, so no runt pulses occur. It sits after the fixed hard-IP divider and feeds derived enables (6502 bus phase, video, SDRAM refresh timers) that need ratios adjustable by the test controller.

---
 rtl/clkdiv_prog.sv | 72 +++++++
 1 files changed

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider producing a square-wave clock and a
// period-start enable per channel; divisor updates take effect only at period boundaries.
module clkdiv_prog #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 8,
   parameter int DIV_INIT = 5,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                hclkin,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [DIV_W-1:0]    wr_div,
   input  logic                sync,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] pend
);

   // Low only between reset and the first edge: that edge starts the first period everywhere.
   logic started;

   always_ff @(posedge hclkin or posedge reset) begin
      if (reset) started <= 1'b0;
      else       started <= 1'b1;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DIV_W-1:0] cnt, div_cur, div_pend;
      logic [DIV_W-1:0] cnt_nxt, div_nxt, half;
      logic             pend_q, clk_q, ce_q;
      logic             wr_hit, boundary;

      always_comb begin
         wr_hit   = wr_en && (wr_ch == CH_W'(i));
         boundary = !started || sync || (div_cur == '0) ||
                    (cnt == div_cur - DIV_W'(1));
         div_nxt  = div_cur;
         cnt_nxt  = cnt + DIV_W'(1);
         if (boundary) begin
            cnt_nxt = '0;
            if (wr_hit)      div_nxt = wr_div;
            else if (pend_q) div_nxt = div_pend;
         end
         // ceil(N/2) without needing an extra bit for N = 2^DIV_W-1
         half = (div_nxt >> 1) + DIV_W'(div_nxt[0]);
      end

      always_ff @(posedge hclkin or posedge reset) begin
         if (reset) begin
            cnt      <= '0;
            div_cur  <= DIV_W'(DIV_INIT);
            div_pend <= '0;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            ce_q     <= 1'b0;
         end else begin
            cnt     <= cnt_nxt;
            div_cur <= div_nxt;
            if (wr_hit) div_pend <= wr_div;
            pend_q  <= !boundary && (pend_q || wr_hit);
            clk_q   <= (div_nxt != '0) && (cnt_nxt < half);
            ce_q    <= (div_nxt != '0) && (cnt_nxt == '0);
         end
      end

      assign clk_out[i] = clk_q;
      assign ce[i]      = ce_q;
      assign pend[i]    = pend_q;
   end

endmodule
